// File: rtl/pp_pipeline_accel_pkg.sv
// pp_pipeline_accel_pkg: shared FSM state type and default widths for the pre-processing pipeline
// No ports; imported by the egress adapter and reused by the FIFO wrappers.
package pp_pipeline_accel_pkg;
    localparam int PP_DATA_WIDTH = 16;
    localparam int PP_DIM_WIDTH  = 12;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/pp_pipeline_accel_fifo_to_axis_tx_axis_out_reg.sv
// pp_pipeline_accel_axis_out_reg: single registered AXI4-Stream output stage with a sideband
// Ports: clk/reset; load with load_data/load_side writes the stage; tready is the downstream accept;
// tvalid/tdata/tside hold the current beat until it is accepted.
module pp_pipeline_accel_axis_out_reg #(
    parameter int DATA_WIDTH = 16,
    parameter int SIDE_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [SIDE_WIDTH-1:0] load_side,
    input  logic                  tready,
    output logic                  tvalid,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic [SIDE_WIDTH-1:0] tside
);
    always_ff @(posedge clk) begin
        if (reset) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tside  <= '0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
            tside  <= load_side;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end
endmodule

// File: rtl/pp_pipeline_accel_fifo_to_axis_tx.sv
// pp_pipeline_accel_fifo_to_axis_tx: drains an ap_fifo read port into a framed AXI4-Stream master
// Ports: clk/reset; start/rows/cols request one frame, busy/done report progress;
// fifo_empty_n/fifo_read/fifo_dout is the fall-through FIFO read side;
// m_axis_* is the stream master with tuser on the first beat and tlast at each line end.
module pp_pipeline_accel_fifo_to_axis_tx
    import pp_pipeline_accel_pkg::*;
#(
    parameter int DATA_WIDTH = PP_DATA_WIDTH,
    parameter int DIM_WIDTH  = PP_DIM_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  rows,
    input  logic [DIM_WIDTH-1:0]  cols,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty_n,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast
);
    state_t state, state_nx;
    logic [DIM_WIDTH-1:0] rows_q, cols_q, col_cnt, row_cnt;
    logic first, accept, load, col_end, row_end;
    assign accept  = (state == IDLE) && start;
    assign col_end = col_cnt == cols_q - DIM_WIDTH'(1);
    assign row_end = row_cnt == rows_q - DIM_WIDTH'(1);
    // tready reaches the pop strobe through a single gate so the stage can refill on the accept cycle
    assign load      = (state == RUN) & fifo_empty_n & (~m_axis_tvalid | m_axis_tready);
    assign fifo_read = load;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            first   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rows_q  <= rows;
                cols_q  <= cols;
                col_cnt <= '0;
                row_cnt <= '0;
                first   <= 1'b1;
            end else if (load) begin
                col_cnt <= col_end ? '0 : col_cnt + DIM_WIDTH'(1);
                row_cnt <= col_end ? row_cnt + DIM_WIDTH'(1) : row_cnt;
                first   <= 1'b0;
            end
        end
    end
    always_comb begin
        state_nx = state;
        busy     = (state == RUN) || (state == DRAIN);
        done     = state == DONE;
        case (state)
            IDLE:    state_nx = !start ? IDLE : (rows != '0 && cols != '0) ? RUN : DONE;
            RUN:     state_nx = (load && col_end && row_end) ? DRAIN : RUN;
            // in DRAIN the stage can only hold the final pixel, so any handshake ends the frame
            DRAIN:   state_nx = (m_axis_tvalid && m_axis_tready) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    pp_pipeline_accel_axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIDE_WIDTH (2)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (fifo_dout),
        .load_side ({first, col_end}),
        .tready    (m_axis_tready),
        .tvalid    (m_axis_tvalid),
        .tdata     (m_axis_tdata),
        .tside     ({m_axis_tuser, m_axis_tlast})
    );
endmodule

// File: tb/tb_pp_pipeline_accel_fifo_to_axis_tx.sv
// tb_pp_pipeline_accel_fifo_to_axis_tx: randomized frame bench with a FIFO model and expected-beat queue
module tb_pp_pipeline_accel_fifo_to_axis_tx;
    localparam int DW = 16;
    localparam int AW = 12;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, fifo_empty_n = 1'b0, m_axis_tready = 1'b1;
    logic [AW-1:0] rows = '0, cols = '0;
    logic [DW-1:0] fifo_dout = '0;
    logic busy, done, fifo_read, m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
        logic          eof;
    } beat_t;
    logic [DW-1:0] fifo_q[$];
    beat_t exp_q[$];
    int n_vec = 0, n_err = 0, n_reads = 0, n_beats = 0, cyc_n = 0, mode = 0;
    bit en = 1'b1, s_read = 1'b0, hold_prev = 1'b0, done_exp = 1'b0, busy_exp = 1'b0;
    logic [DW+1:0] prev_beat = '0;

    always #5 clk = ~clk;

    pp_pipeline_accel_fifo_to_axis_tx dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .rows          (rows),
        .cols          (cols),
        .busy          (busy),
        .done          (done),
        .fifo_empty_n  (fifo_empty_n),
        .fifo_read     (fifo_read),
        .fifo_dout     (fifo_dout),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic upd_fifo();
        fifo_empty_n = en && fifo_q.size() != 0;
        fifo_dout    = fifo_q.size() != 0 ? fifo_q[0] : '0;
    endtask

    task automatic cyc();
        beat_t e;
        @(posedge clk);
        #1;
        if (s_read && fifo_q.size() != 0) void'(fifo_q.pop_front());
        cyc_n++;
        m_axis_tready = mode == 1 ? (cyc_n % 4 == 0 || cyc_n % 4 == 3) :
                        mode == 3 ? 1'($urandom_range(0, 1)) : 1'b1;
        en = mode == 2 ? cyc_n[0] : mode == 3 ? ($urandom_range(0, 3) != 0) : 1'b1;
        upd_fifo();
        @(negedge clk);
        chk("done", 32'(done), 32'(done_exp));
        chk("busy", 32'(busy), 32'(busy_exp));
        done_exp = 1'b0;
        if (hold_prev) begin
            chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
            chk("hold_beat", 32'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'(prev_beat));
        end
        hold_prev = m_axis_tvalid && !m_axis_tready;
        prev_beat = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        s_read = fifo_read;
        if (fifo_read) begin
            n_reads++;
            chk("read_empty_n", 32'(fifo_empty_n), 32'd1);
            chk("read_backpressure", 32'(hold_prev), 32'd0);
        end
        if (m_axis_tvalid && m_axis_tready) begin
            n_beats++;
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tdata", 32'(m_axis_tdata), 32'(e.d));
                chk("tuser", 32'(m_axis_tuser), 32'(e.u));
                chk("tlast", 32'(m_axis_tlast), 32'(e.l));
                if (e.eof) begin
                    done_exp = 1'b1;
                    busy_exp = 1'b0;
                end
            end
        end
    endtask

    task automatic load_frame(input int r, input int c, input bit seq);
        beat_t b;
        for (int i = 0; i < r * c; i++) begin
            b.d   = seq ? DW'(16 + i) : DW'($urandom);
            b.u   = i == 0;
            b.l   = i % c == c - 1;
            b.eof = i == r * c - 1;
            fifo_q.push_back(b.d);
            exp_q.push_back(b);
        end
        upd_fifo();
    endtask

    task automatic run_frame(input int r, input int c, input bit seq, input bit poke);
        int n, rd0, guard;
        n = r * c;
        load_frame(r, c, seq);
        rows  = AW'(r);
        cols  = AW'(c);
        start = 1'b1;
        if (n == 0) done_exp = 1'b1;
        else busy_exp = 1'b1;
        rd0 = n_reads;
        cyc();
        start = 1'b0;
        guard = 0;
        if (n != 0) begin
            while (!done && guard < 2000) begin
                if (poke && guard == 3) begin
                    start = 1'b1;
                    rows  = AW'(7);
                    cols  = AW'(9);
                end
                cyc();
                start = 1'b0;
                guard++;
            end
            chk("frame_done", 32'(done), 32'd1);
        end
        cyc();
        chk("reads", 32'(n_reads - rd0), 32'(n));
        chk("beats_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int b0, guard;
        upd_fifo();
        cyc();
        cyc();
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_fifo_read", 32'(fifo_read), 32'd0);
        reset = 1'b0;
        mode = 0; run_frame(2, 3, 1'b1, 1'b0);
        mode = 1; run_frame(3, 5, 1'b0, 1'b0);
        mode = 2; run_frame(4, 4, 1'b0, 1'b0);
        mode = 0; run_frame(0, 5, 1'b0, 1'b0);
        run_frame(3, 0, 1'b0, 1'b0);
        mode = 3; run_frame(4, 4, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) run_frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 6)), 1'b0, 1'b0);
        mode = 1; run_frame(1, 1, 1'b0, 1'b0);
        mode = 0;
        load_frame(3, 4, 1'b0);
        rows = AW'(3);
        cols = AW'(4);
        start = 1'b1;
        busy_exp = 1'b1;
        b0 = n_beats;
        cyc();
        start = 1'b0;
        guard = 0;
        while (n_beats - b0 < 5 && guard < 200) begin
            cyc();
            guard++;
        end
        chk("pre_reset_beats", 32'(n_beats - b0), 32'd5);
        reset = 1'b1;
        exp_q.delete();
        busy_exp = 1'b0;
        done_exp = 1'b0;
        hold_prev = 1'b0;
        cyc();
        reset = 1'b0;
        chk("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        fifo_q.delete();
        s_read = 1'b0;
        upd_fifo();
        cyc();
        run_frame(3, 4, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
